// File: rtl/simple_processor.sv
// simple_processor: multi-cycle 8-bit-address / 32-bit-data accumulator CPU.
// Fetches 12-bit instructions from an external registered-read ROM and
// reads/writes an external registered-read 256x32 data RAM.
// Optional feature macro: SIMPLEPROC_SHIFT_EN (builds the SHL/SHR shifter;
// when undefined, opcodes D and E behave as NOP).
module simple_processor (
    input  logic               clk,
    input  logic               rst,
    input  logic        [11:0] instr,
    output logic        [7:0]  instr_addr,
    output logic               mem_wr,
    output logic        [7:0]  mem_addr,
    input  logic signed [31:0] mem_data_in,
    output logic signed [31:0] mem_data_out
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_MEMRD  = 3'd2,
        S_EXEC   = 3'd3,
        S_WRITE  = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [3:0] OP_LD   = 4'h1;
    localparam logic [3:0] OP_ST   = 4'h2;
    localparam logic [3:0] OP_ADD  = 4'h3;
    localparam logic [3:0] OP_SUB  = 4'h4;
    localparam logic [3:0] OP_AND  = 4'h5;
    localparam logic [3:0] OP_OR   = 4'h6;
    localparam logic [3:0] OP_XOR  = 4'h7;
    localparam logic [3:0] OP_LDI  = 4'h8;
    localparam logic [3:0] OP_ADDI = 4'h9;
    localparam logic [3:0] OP_JMP  = 4'hA;
    localparam logic [3:0] OP_JZ   = 4'hB;
    localparam logic [3:0] OP_JN   = 4'hC;
`ifdef SIMPLEPROC_SHIFT_EN
    localparam logic [3:0] OP_SHL  = 4'hD;
    localparam logic [3:0] OP_SHR  = 4'hE;
`endif
    localparam logic [3:0] OP_HALT = 4'hF;

    state_t             state_q;
    logic        [7:0]  pc_q;
    logic signed [31:0] acc_q;
    logic        [11:0] ir_q;
    logic               mem_wr_q;

    logic        [3:0]  op_s;
    logic        [7:0]  k_s;
    logic signed [31:0] imm_s;
    logic        [7:0]  pc_inc_s;
    logic signed [31:0] acc_d;
    logic        [7:0]  pc_d;

    // Chooses the state following DECODE from the freshly fetched opcode.
    function automatic state_t decode_next(input logic [3:0] op);
        state_t nxt;
        case (op)
            OP_LD, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: nxt = S_MEMRD;
            OP_ST:   nxt = S_WRITE;
            OP_HALT: nxt = S_HALT;
            default: nxt = S_EXEC;
        endcase
        return nxt;
    endfunction

    assign op_s     = ir_q[11:8];
    assign k_s      = ir_q[7:0];
    assign imm_s    = {{24{k_s[7]}}, k_s};
    assign pc_inc_s = pc_q + 8'd1;

    // EXEC-stage datapath: next accumulator and next PC for the latched instruction.
    always_comb begin
        acc_d = acc_q;
        pc_d  = pc_inc_s;
        case (op_s)
            OP_LD:   acc_d = mem_data_in;
            OP_ADD:  acc_d = acc_q + mem_data_in;
            OP_SUB:  acc_d = acc_q - mem_data_in;
            OP_AND:  acc_d = acc_q & mem_data_in;
            OP_OR:   acc_d = acc_q | mem_data_in;
            OP_XOR:  acc_d = acc_q ^ mem_data_in;
            OP_LDI:  acc_d = imm_s;
            OP_ADDI: acc_d = acc_q + imm_s;
            OP_JMP:  pc_d  = k_s;
            OP_JZ: begin
                if (acc_q == 32'sd0) begin
                    pc_d = k_s;
                end else begin
                    pc_d = pc_inc_s;
                end
            end
            OP_JN: begin
                if (acc_q[31]) begin
                    pc_d = k_s;
                end else begin
                    pc_d = pc_inc_s;
                end
            end
`ifdef SIMPLEPROC_SHIFT_EN
            OP_SHL:  acc_d = acc_q <<< 1;
            OP_SHR:  acc_d = acc_q >>> 1;
`endif
            default: begin
                acc_d = acc_q;
                pc_d  = pc_inc_s;
            end
        endcase
    end

    // Control FSM and architectural registers, with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_FETCH;
            pc_q     <= 8'd0;
            acc_q    <= 32'sd0;
            ir_q     <= 12'd0;
            mem_wr_q <= 1'b0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    state_q  <= S_DECODE;
                    mem_wr_q <= 1'b0;
                end
                S_DECODE: begin
                    ir_q     <= instr;
                    state_q  <= decode_next(instr[11:8]);
                    mem_wr_q <= (instr[11:8] == OP_ST);
                end
                S_MEMRD: begin
                    state_q  <= S_EXEC;
                    mem_wr_q <= 1'b0;
                end
                S_EXEC: begin
                    acc_q    <= acc_d;
                    pc_q     <= pc_d;
                    state_q  <= S_FETCH;
                    mem_wr_q <= 1'b0;
                end
                S_WRITE: begin
                    pc_q     <= pc_inc_s;
                    state_q  <= S_FETCH;
                    mem_wr_q <= 1'b0;
                end
                S_HALT: begin
                    state_q  <= S_HALT;
                    mem_wr_q <= 1'b0;
                end
                default: begin
                    state_q  <= S_FETCH;
                    mem_wr_q <= 1'b0;
                end
            endcase
        end
    end

    // The write strobe is gated by reset so a store cycle that meets reset never lands.
    assign mem_wr       = mem_wr_q & rst;
    assign instr_addr   = pc_q;
    assign mem_addr     = ir_q[7:0];
    assign mem_data_out = acc_q;

endmodule

// File: tb/tb_simple_processor.sv
// Self-checking bench for simple_processor: ISA-level reference model feeds a
// scoreboard of expected fetch observations and RAM writes; a monitor compares.
module tb_simple_processor;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic        [11:0] instr = 12'd0;
    logic        [7:0]  instr_addr;
    logic               mem_wr;
    logic        [7:0]  mem_addr;
    logic signed [31:0] mem_data_in = 32'sd0;
    logic signed [31:0] mem_data_out;

    always #5 clk = ~clk;

    simple_processor dut (
        .clk          (clk),
        .rst          (rst),
        .instr        (instr),
        .instr_addr   (instr_addr),
        .mem_wr       (mem_wr),
        .mem_addr     (mem_addr),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out)
    );

    logic [11:0] rom     [256];
    logic [31:0] ram     [256];
    logic [31:0] ref_ram [256];

    // Registered-read ROM and RAM; RAM read returns old data on a same-address write.
    always @(posedge clk) begin
        instr       <= rom[instr_addr];
        mem_data_in <= ram[mem_addr];
        if (mem_wr) ram[mem_addr] = mem_data_out;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          c;
        logic [7:0]  a;
        logic [31:0] d;
    } ev_t;

    ev_t wq[$];
    ev_t oq[$];
    int  checks = 0;
    int  passes = 0;
    bit  active = 1'b0;
    int  base   = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s @cyc %0d: got %h, expected %h", name, cyc, act, exp);
    endfunction

    // Monitor: compare DUT outputs against queued expectations on each falling edge.
    always @(negedge clk) begin
        if (active) begin
            if (mem_wr === 1'b1) begin
                if (wq.size() > 0 && wq[0].c == cyc) begin
                    check("wr_addr", {24'd0, mem_addr}, {24'd0, wq[0].a});
                    check("wr_data", mem_data_out, wq[0].d);
                    void'(wq.pop_front());
                end else begin
                    check("wr_strobe_unexpected", {31'd0, mem_wr}, 32'd0);
                end
            end else if (wq.size() > 0 && wq[0].c == cyc) begin
                check("wr_strobe_missing", {31'd0, mem_wr}, 32'd1);
                void'(wq.pop_front());
            end
            if (oq.size() > 0 && oq[0].c == cyc) begin
                check("pc", {24'd0, instr_addr}, {24'd0, oq[0].a});
                check("acc", mem_data_out, oq[0].d);
                void'(oq.pop_front());
            end
        end
    end

    // ISA-level reference: executes n instructions, queuing timed observations.
    task automatic model(input int n, output int end_rel);
        logic [7:0]  pc, npc, k;
        logic [31:0] acc, kx;
        logic [11:0] w;
        logic [3:0]  op;
        int          t, lat;
        bit          halted;
        pc = 8'd0; acc = 32'd0; t = 0; halted = 1'b0;
        for (int i = 0; i < n; i++) begin
            oq.push_back('{base + t, pc, acc});
            w = rom[pc]; op = w[11:8]; k = w[7:0];
            kx = {{24{k[7]}}, k};
            lat = 3; npc = pc + 8'd1;
            case (op)
                4'h1: begin acc = ref_ram[k]; lat = 4; end
                4'h2: begin ref_ram[k] = acc; wq.push_back('{base + t + 2, k, acc}); end
                4'h3: begin acc = acc + ref_ram[k]; lat = 4; end
                4'h4: begin acc = acc - ref_ram[k]; lat = 4; end
                4'h5: begin acc = acc & ref_ram[k]; lat = 4; end
                4'h6: begin acc = acc | ref_ram[k]; lat = 4; end
                4'h7: begin acc = acc ^ ref_ram[k]; lat = 4; end
                4'h8: acc = kx;
                4'h9: acc = acc + kx;
                4'hA: npc = k;
                4'hB: if (acc == 32'd0) npc = k;
                4'hC: if (acc[31]) npc = k;
                4'hD: begin
`ifdef SIMPLEPROC_SHIFT_EN
                    acc = acc << 1;
`endif
                end
                4'hE: begin
`ifdef SIMPLEPROC_SHIFT_EN
                    acc = {acc[31], acc[31:1]};
`endif
                end
                4'hF: halted = 1'b1;
                default: ;
            endcase
            if (halted) begin
                for (int c = 2; c < 6; c++) oq.push_back('{base + t + c, pc, acc});
                end_rel = t + 6;
                return;
            end
            pc = npc;
            t  = t + lat;
        end
        oq.push_back('{base + t, pc, acc});
        end_rel = t;
    endtask

    task automatic reset_checks(string tag);
        check({tag, "_rst_iaddr"}, {24'd0, instr_addr}, 32'd0);
        check({tag, "_rst_wr"}, {31'd0, mem_wr}, 32'd0);
        check({tag, "_rst_maddr"}, {24'd0, mem_addr}, 32'd0);
        check({tag, "_rst_dout"}, mem_data_out, 32'd0);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) begin
            rom[i] = 12'h000;
            ram[i] = 32'd0;
        end
    endtask

    // Releases reset, runs the model, and re-asserts reset off cycles after the model end.
    task automatic run_prog(input int n, input int off);
        int end_rel, target;
        for (int i = 0; i < 256; i++) ref_ram[i] = ram[i];
        @(posedge clk); #1;
        rst = 1'b1; base = cyc; active = 1'b1;
        model(n, end_rel);
        target = base + end_rel + off;
        while (cyc < target) begin
            @(posedge clk); #1;
        end
        rst = 1'b0;
    endtask

    task automatic end_run(string tag);
        @(posedge clk); #1;
        active = 1'b0;
        check({tag, "_wq_drain"}, wq.size(), 32'd0);
        check({tag, "_oq_drain"}, oq.size(), 32'd0);
        wq.delete(); oq.delete();
        @(posedge clk); #1;
        @(negedge clk);
        reset_checks(tag);
    endtask

    initial begin
        clear_mem();
        repeat (2) @(posedge clk);
        #1; @(negedge clk);
        reset_checks("por");

        // Load / add / store / halt
        clear_mem();
        rom[0] = 12'h10A; rom[1] = 12'h30B; rom[2] = 12'h20C; rom[3] = 12'hF00;
        ram[10] = 32'd5; ram[11] = 32'hFFFF_FFFD;
        run_prog(64, 0);
        @(negedge clk);
        check("ldst_pc", {24'd0, instr_addr}, 32'd3);
        check("ldst_acc", mem_data_out, 32'd2);
        end_run("ldst");
        check("ldst_m12", ram[12], 32'd2);

        // Immediate wrap and JZ, then negative immediate
        clear_mem();
        rom[0] = 12'h87F; rom[1] = 12'h981; rom[2] = 12'hB20;
        rom[8'h20] = 12'h880; rom[8'h21] = 12'hF00;
        run_prog(64, 0);
        @(negedge clk);
        check("imm_pc", {24'd0, instr_addr}, 32'h21);
        check("imm_acc", mem_data_out, 32'hFFFF_FF80);
        end_run("imm");

        // JN taken then not taken
        clear_mem();
        rom[0] = 12'h8FF; rom[1] = 12'hC05; rom[5] = 12'h801; rom[6] = 12'hC05; rom[7] = 12'hF00;
        run_prog(64, 0);
        @(negedge clk);
        check("jn_pc", {24'd0, instr_addr}, 32'd7);
        check("jn_acc", mem_data_out, 32'd1);
        end_run("jn");

        // PC wrap from 255 to 0
        clear_mem();
        rom[0] = 12'hBFE; rom[8'hFE] = 12'h801; rom[8'hFF] = 12'h000; rom[1] = 12'hF00;
        run_prog(64, 0);
        @(negedge clk);
        check("wrap_pc", {24'd0, instr_addr}, 32'd1);
        end_run("wrap");

        // Shift right (configuration dependent)
        clear_mem();
        rom[0] = 12'h8FC; rom[1] = 12'hE00; rom[2] = 12'hF00;
        run_prog(64, 0);
        @(negedge clk);
`ifdef SIMPLEPROC_SHIFT_EN
        check("shr_acc", mem_data_out, 32'hFFFF_FFFE);
`else
        check("shr_acc", mem_data_out, 32'hFFFF_FFFC);
`endif
        check("shr_pc", {24'd0, instr_addr}, 32'd2);
        end_run("shr");

        // Reset coinciding with the WRITE cycle suppresses the store
        clear_mem();
        rom[0] = 12'h205; ram[5] = 32'h1234_5678;
        run_prog(0, 2);
        end_run("rstwr");
        check("rstwr_m5", ram[5], 32'h1234_5678);

        // Randomized programs with random abort point
        for (int r = 0; r < 24; r++) begin
            for (int i = 0; i < 256; i++) begin
                logic [3:0] op;
                op = 4'($urandom_range(0, 15));
                if (op >= 4'h1 && op <= 4'h7) rom[i] = {op, 8'($urandom_range(0, 15))};
                else rom[i] = {op, 8'($urandom)};
                ram[i] = $urandom;
            end
            run_prog(40, $urandom_range(0, 2));
            end_run("rand");
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/simple_processor.md
# simple_processor

8-bit-address, 32-bit-data accumulator processor with separate instruction and data memories. The processor fetches 12-bit instructions from a 256-word instruction ROM (`mem_instr`) and reads and writes a 256 × 32 data RAM (`mem_data`). It executes a multi-cycle state machine and is the top compute block of the simple computer.

## Interface
- No parameters. Widths are fixed: 8-bit addresses, 12-bit instructions, 32-bit signed data.
- Clocking and reset: one clock; reset is synchronous and active-low.
- `clk` — input, 1 bit — single clock; everything is rising-edge.
- `rst` — input, 1 bit — synchronous active-low reset.
- `instr` — input, 12 bits — instruction word from `mem_instr`.
- `instr_addr` — output, 8 bits — instruction address; equals the PC.
- `mem_wr` — output, 1 bit — data RAM write strobe.
- `mem_addr` — output, 8 bits — data RAM address.
- `mem_data_in` — input, signed 32 bits — read data from `mem_data`.
- `mem_data_out` — output, signed 32 bits — write data to `mem_data`.
- `mem_instr` ports: `clk`, `addr`[7:0], `data`[11:0].
  - Registered read: `data` equals ROM[`addr`] sampled at the previous edge.
  - Contents are loaded by `$readmemh("instr.hex")`.
- `mem_data` ports: `clk`, `wr`, `addr`[7:0], `data_in`[31:0], `data_out`[31:0].
  - Synchronous write when `wr` = 1.
  - Registered read returns the old data when reading the address being written.
  - Contents are loaded by `$readmemh("data.hex")`.

## Operation
- Instruction format: `instr[11:8]` is the opcode; `instr[7:0]` is the operand `k`.
- Architectural state: PC (8 bits), ACC (signed 32 bits), IR (12 bits), FSM state.
- Opcodes (M[k] is the data RAM word at address k):
  - 0 NOP.
  - 1 LD: ACC = M[k].
  - 2 ST: M[k] = ACC.
  - 3 ADD: ACC += M[k].
  - 4 SUB: ACC -= M[k].
  - 5 AND: ACC &= M[k].
  - 6 OR: ACC |= M[k].
  - 7 XOR: ACC ^= M[k].
  - 8 LDI: ACC = sign-extended k.
  - 9 ADDI: ACC += sign-extended k.
  - A JMP: PC = k.
  - B JZ: PC = k if ACC == 0.
  - C JN: PC = k if ACC[31] == 1.
  - D SHL: ACC <<= 1 (config-dependent, see Configuration).
  - E SHR: arithmetic shift right by 1 (config-dependent, see Configuration).
  - F HALT.
- Arithmetic wraps modulo 2^32; there are no flags other than the ACC tests used by JZ/JN.
- PC increments by 1 modulo 256, so address 255 wraps to 0. A jump that is not taken also increments the PC.
- FSM states and transitions:
  - FETCH: `instr_addr` = PC. Next state is DECODE.
  - DECODE: IR ← `instr`.
    - Opcodes 1, 3–7 go to MEMRD.
    - Opcode 2 goes to WRITE.
    - Opcode F goes to HALT.
    - All other opcodes go to EXEC.
  - MEMRD: `mem_addr` = IR[7:0], `mem_wr` = 0. Next state is EXEC.
  - EXEC: update ACC using `mem_data_in` or the immediate; update PC. Next state is FETCH.
  - WRITE: `mem_addr` = IR[7:0], `mem_data_out` = ACC, `mem_wr` = 1. PC increments. Next state is FETCH.
  - HALT: terminal state. PC and ACC are frozen, `mem_wr` = 0. Only reset exits it.
- `mem_wr` is 1 only in the WRITE state.
- `mem_addr` = IR[7:0] in all states.
- `mem_data_out` = ACC in all states.

## Timing
- Reset: when `rst` = 0 at a rising edge, the next cycle has:
  - PC = 0, ACC = 0, IR = 0, state = FETCH;
  - `instr_addr` = 0, `mem_addr` = 0, `mem_wr` = 0, `mem_data_out` = 0.
- Reset mid-instruction aborts the instruction. A WRITE cycle that coincides with reset is suppressed: `mem_wr` is forced to 0.
- Latency per instruction:
  - LD/ALU-memory: 4 cycles (FETCH, DECODE, MEMRD, EXEC).
  - ST: 3 cycles (FETCH, DECODE, WRITE).
  - Register/immediate/jump: 3 cycles (FETCH, DECODE, EXEC).
- Memory read latency is 1 cycle.
  - `instr` is valid in DECODE.
  - `mem_data_in` is valid in EXEC following MEMRD.
- Store followed by a load of the same address: RAM is written at the end of WRITE, so a later MEMRD returns the new value.

## Configuration
- Macro `SIMPLEPROC_SHIFT_EN`.
- Defined: opcode D = SHL by 1; opcode E = SHR by 1, arithmetic (sign-preserving).
- Undefined: opcodes D and E execute as NOP (3 cycles, PC + 1) and the shifter logic is not built.

## Test plan
- Reset: hold `rst` = 0 for 2 edges → `instr_addr` = 0, `mem_wr` = 0, `mem_data_out` = 0. Release → first FETCH is at address 0.
- Load/add/store: M[10] = 5, M[11] = −3; program LD 10, ADD 11, ST 12, HALT → M[12] = 2.
  - `mem_wr` is high for exactly one cycle, with `mem_addr` = 12.
  - Then the PC freezes at 3.
- Immediate wrap: LDI 0x7F, ADDI 0x81, JZ 0x20 → ACC = 0 and the next fetch is at 0x20.
  - Also: LDI 0x80 → ACC = 0xFFFFFF80.
- Negative branch: LDI 0xFF, JN 5 → fetch at 5. LDI 1, JN 5 → fetch at the next sequential address.
- PC wrap: NOP at address 255 → next `instr_addr` = 0.
- Shift: LDI 0xFC, SHR →
  - with `SIMPLEPROC_SHIFT_EN`: ACC = 0xFFFFFFFE;
  - without it: ACC stays 0xFFFFFFFC.
